// File: rtl/display_pkg.sv
// Shared display constants and types for the note sprite path.
package display_pkg;

    localparam int SPR_W    = 40;
    localparam int SPR_H    = 45;
    localparam int SPR_BITS = SPR_W * SPR_H;

    // Duration one-hot codes carried in note_type[5:2].
    localparam logic [3:0] DUR_WHOLE   = 4'b1000;
    localparam logic [3:0] DUR_HALF    = 4'b0100;
    localparam logic [3:0] DUR_QUARTER = 4'b0010;
    localparam logic [3:0] DUR_EIGHTH  = 4'b0001;

    typedef struct packed {
        logic [3:0] dur;
        logic       stem_down;
        logic       sharp;
    } note_type_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] step;
        note_type_t ntype;
    } slot_t;

endpackage

// File: rtl/slot_hit_calc.sv
// Combinational hit test and sprite bit address for one staff slot.
module slot_hit_calc
    import display_pkg::*;
#(
    parameter int SLOT_IDX     = 0,
    parameter int SLOT_X0      = 64,
    parameter int STAFF_BASE_Y = 300,
    parameter int STEP_PX      = 5
) (
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        pix_active,
    input  logic        slot_valid,
    input  logic [4:0]  slot_step,
    output logic        hit,
    output logic [14:0] addr
);

    logic signed [10:0] w_dx;
    logic signed [10:0] w_y_top;
    logic signed [10:0] w_row;
    logic        [14:0] w_row_ext;
    logic        [14:0] w_col_ext;

    // Signed geometry: pixel offset into the slot row and into the sprite rows.
    always_comb begin
        w_dx      = $signed({1'b0, hcount}) - $signed(11'(SLOT_X0));
        w_y_top   = $signed(11'(STAFF_BASE_Y)) - $signed(11'(slot_step) * 11'(STEP_PX));
        w_row     = $signed({1'b0, vcount}) - w_y_top;
        w_row_ext = {9'b0, w_row[5:0]};
        w_col_ext = {9'b0, w_dx[5:0]};
        // dx[10:6] is the slot index once dx is known non-negative.
        hit = pix_active && slot_valid && !w_dx[10]
              && (w_dx[10:6] == 5'(SLOT_IDX))
              && (w_dx[5:0] < 6'(SPR_W))
              && (w_row >= 11'sd0)
              && (w_row < $signed(11'(SPR_H)));
        // row*40 as (row<<5)+(row<<3); masked so non-hit slots OR in zero.
        addr = hit ? ((w_row_ext << 5) + (w_row_ext << 3) + w_col_ext) : 15'd0;
    end

endmodule

// File: rtl/note_sprite_scheduler.sv
// Note slot buffer plus per-pixel sprite hit pipeline feeding the sprite ROM.
module note_sprite_scheduler
    import display_pkg::*;
#(
    parameter int N_SLOTS        = 8,
    parameter int SLOT_X0        = 64,
    parameter int SLOT_PITCH_LG2 = 6,
    parameter int STAFF_BASE_Y   = 300,
    parameter int STEP_PX        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        pix_active,
    input  logic        frame_blank,
    input  logic        clear,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [4:0]  note_step,
    input  logic [5:0]  note_type_in,
    output logic [14:0] rom_addr,
    output logic [5:0]  note_type,
    output logic        hit_aligned,
    output logic [3:0]  note_count
);

    localparam int PTR_W = $clog2(N_SLOTS);

    slot_t             r_slots [N_SLOTS];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [3:0]        r_note_count;
    logic [14:0]       r_rom_addr;
    logic [5:0]        r_note_type;
    logic [2:0]        r_hit_pipe;

    logic              w_accept;
    logic [N_SLOTS-1:0] w_slot_hit;
    logic [14:0]       w_slot_addr [N_SLOTS];
    logic              w_hit;
    logic [14:0]       w_addr;
    logic [5:0]        w_type;

    // Notes may only land during blank, and never alongside a clear.
    assign note_ready = frame_blank && !clear && !reset;
    assign w_accept   = note_valid && note_ready;

    // Slot buffer: clear, wrap-to-new-page on full, or append at wr_ptr.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset || clear) begin
            // NOTE: only valid bits are reset; step/type are don't-care while invalid, so no reset fan-out on the data.
            for (int i = 0; i < N_SLOTS; i++) r_slots[i].valid <= 1'b0;
            r_wr_ptr     <= '0;
            r_note_count <= 4'd0;
        end else if (w_accept) begin
            if (r_note_count == 4'(N_SLOTS)) begin
                for (int i = 1; i < N_SLOTS; i++) r_slots[i].valid <= 1'b0;
                r_slots[0]   <= '{valid: 1'b1, step: note_step, ntype: note_type_in};
                r_wr_ptr     <= PTR_W'(1);
                r_note_count <= 4'd1;
            end else begin
                r_slots[r_wr_ptr] <= '{valid: 1'b1, step: note_step, ntype: note_type_in};
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_note_count      <= r_note_count + 4'd1;
            end
        end
    end

    // Stage 0: one hit calculator per slot; at most one can hit at a time.
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        slot_hit_calc #(
            .SLOT_IDX    (g),
            .SLOT_X0     (SLOT_X0),
            .STAFF_BASE_Y(STAFF_BASE_Y),
            .STEP_PX     (STEP_PX)
        ) u_calc (
            .hcount    (hcount),
            .vcount    (vcount),
            .pix_active(pix_active),
            .slot_valid(r_slots[g].valid),
            .slot_step (r_slots[g].step),
            .hit       (w_slot_hit[g]),
            .addr      (w_slot_addr[g])
        );
    end

    // OR-reduce the per-slot results into a single hit, address and type.
    always_comb begin
        // NOTE: defaults first so no path leaves these unassigned and infers a latch.
        w_hit  = |w_slot_hit;
        w_addr = 15'd0;
        w_type = 6'd0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_addr = w_addr | w_slot_addr[i];
            w_type = w_type | (w_slot_hit[i] ? r_slots[i].ntype : 6'd0);
        end
    end

    // Stage 1 registers plus the 3-deep hit delay matching the ROM's 2-cycle read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_addr  <= 15'd0;
            r_note_type <= 6'd0;
            r_hit_pipe  <= 3'b000;
        end else begin
            r_rom_addr  <= w_addr;
            r_note_type <= w_type;
            r_hit_pipe  <= {r_hit_pipe[1:0], w_hit};
        end
    end

    assign rom_addr    = r_rom_addr;
    assign note_type   = r_note_type;
    assign hit_aligned = r_hit_pipe[2];
    assign note_count  = r_note_count;

endmodule
